spi_slave_core: RTL

- SPI target (slave) shift engine; the counterpart of the SPI master's edge-counting serializer.
- Runs entirely in the pclk domain and oversamples the external sclk, cs_n and mosi pins.
- Receives characters of 1..32 bits from an external master and drives miso from a one-entry transmit holding register.
- Sits between the pad ring and the APB register block of the SPI target.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_counter.sv | 24 ++
 rtl/spi_pin_sync.sv | 34 +++
 rtl/spi_slave_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI target shift engine.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;

  // Edge counter width: two edges per bit, up to 32 bits per character.
  localparam int unsigned MAX_LEN_W = 6;

  function automatic logic [MAX_LEN_W-1:0] char_len_decode(input logic [4:0] code);
    return (code == 5'd0) ? MAX_LEN_W'(32) : {1'b0, code};
  endfunction

endpackage

// File: rtl/spi_counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module spi_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall pulses taken
// from the last stage and its registered copy.
module spi_pin_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{ResetVal}};
      last_q <= ResetVal;
    end else begin
      sync_q <= (sync_q << 1) | SyncStages'(pin_i);
      last_q <= sync_q[SyncStages-1];
    end
  end

  always_comb begin
    level_o = sync_q[SyncStages-1];
    rise_o  = sync_q[SyncStages-1] & ~last_q;
    fall_o  = ~sync_q[SyncStages-1] & last_q;
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI target shift engine: oversamples the pins in the pclk domain, receives
// 1..32-bit characters and drives miso from a one-entry transmit holding register.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               cfg_cpol,
  input  logic               cfg_cpha,
  input  logic               cfg_lsb,
  input  logic [4:0]         cfg_char_len,
  input  logic               sclk_i,
  input  logic               cs_n_i,
  input  logic               mosi_i,
  output logic               miso_o,
  output logic               miso_oe,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               tx_underrun
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_pin_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sclk_sync (
    .clk_i   (pclk),
    .rst_i   (preset),
    .pin_i   (sclk_i),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // cs_n idles high; resetting its synchronizer high avoids a false select.
  spi_pin_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b1)) u_cs_sync (
    .clk_i   (pclk),
    .rst_i   (preset),
    .pin_i   (cs_n_i),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_pin_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_mosi_sync (
    .clk_i   (pclk),
    .rst_i   (preset),
    .pin_i   (mosi_i),
    .level_o (mosi_s),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  logic unused_pins;
  assign unused_pins = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

  spi_slv_state_e       state_q, state_d;
  logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [MAX_LEN_W-1:0] len_q, len_d;
  logic [MAX_LEN-1:0]   tx_shift_q, tx_shift_d;
  logic [MAX_LEN-1:0]   rx_shift_q, rx_shift_d;
  logic [MAX_LEN-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 underrun_q, underrun_d;
  logic                 hold_full_q, hold_full_d;
  logic [MAX_LEN-1:0]   hold_data_q, hold_data_d;

  logic                 active, any_edge, leading, trailing, sample_edge, shift_edge;
  logic                 char_end, cs_start, cs_stop, load;
  logic [MAX_LEN_W:0]   last_edge;
  logic [MAX_LEN_W-1:0] edge_cnt;

  always_comb begin
    active      = (state_q == ACTIVE);
    any_edge    = sclk_rise | sclk_fall;
    leading     = cpol_q ? sclk_fall : sclk_rise;
    trailing    = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trailing : leading;
    shift_edge  = cpha_q ? leading : trailing;
    last_edge   = {len_q, 1'b0} - (MAX_LEN_W + 1)'(1);
    // Character ends on the 2*len-th edge, i.e. while the counter shows 2*len-1.
    char_end    = active && any_edge && ({1'b0, edge_cnt} == last_edge);
    cs_start    = !active && cs_fall;
    cs_stop     = active && cs_rise;
    load        = cs_start || (char_end && !cs_stop);
  end

  spi_counter #(.Width(MAX_LEN_W)) u_edge_cnt (
    .clk_i   (pclk),
    .rst_i   (preset),
    .clr_i   (char_end || cs_start),
    .en_i    (active && any_edge),
    .count_o (edge_cnt)
  );

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    len_d       = len_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;

    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    if (active) begin
      if (sample_edge) begin
        rx_shift_d = lsb_q ? {mosi_s, rx_shift_q[MAX_LEN-1:1]}
                           : {rx_shift_q[MAX_LEN-2:0], mosi_s};
      end
      // With CPHA=1 the first leading edge holds the first bit until it is sampled.
      if (shift_edge && (edge_cnt != '0)) begin
        tx_shift_d = lsb_q ? (tx_shift_q >> 1) : (tx_shift_q << 1);
      end
      if (char_end) begin
        rx_valid_d = 1'b1;
        rx_data_d  = lsb_q ? (rx_shift_d >> (MAX_LEN_W'(MAX_LEN) - len_q)) : rx_shift_d;
        rx_shift_d = '0;
      end
      if (cs_stop) begin
        state_d = IDLE;
      end
    end

    if (load) begin
      state_d    = ACTIVE;
      cpol_d     = cfg_cpol;
      cpha_d     = cfg_cpha;
      lsb_d      = cfg_lsb;
      len_d      = char_len_decode(cfg_char_len);
      rx_shift_d = '0;
      // MSB-first data is left-justified so the outgoing bit is always the top one.
      if (hold_full_q) begin
        tx_shift_d  = cfg_lsb ? hold_data_q
                              : (hold_data_q << (MAX_LEN_W'(MAX_LEN) - len_d));
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      len_q       <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      len_q       <= len_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  always_comb begin
    miso_o      = active ? (lsb_q ? tx_shift_q[0] : tx_shift_q[MAX_LEN-1]) : 1'b0;
    miso_oe     = active;
    busy        = active;
    tx_ready    = !hold_full_q;
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    tx_underrun = underrun_q;
  end

endmodule
